axi_lite_initiator: RTL and testbench
=====================================

# axi_lite_initiator

AXI-Lite initiator that turns single-beat register commands from an internal controller into AXI-Lite write and read transactions. It then returns the AXI-Lite response to that controller. It is the master-side counterpart of the team's AXI-Lite register bridge and drives the same five channels and signal set. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, width of the address on both the command and AXI address channels
- DATA_WIDTH (local constant), 32, fixed data width
- axis_clk  in  1  clock; all logic is rising-edge
- axis_rst_n  in  1  reset, asynchronous, active-low; clock axis_clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator idle and able to accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  32  write data, ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  controller accepts the response
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  32  read data, 0 for writes
- rsp_resp  out  2  captured BRESP or RRESP
- busy  out  1  state is not IDLE
- axis_waddr / axis_waddr_valid (out), axis_waddr_ready (in): ADDR_WIDTH / 1 / 1, write address channel
- axis_wdata / axis_wdata_valid (out), axis_wdata_ready (in): 32 / 1 / 1, write data channel
- axis_bresp (in, 2), axis_bresp_valid (in, 1), axis_bresp_ready (out, 1): write response channel
- axis_raddr / axis_raddr_valid (out), axis_raddr_ready (in): ADDR_WIDTH / 1 / 1, read address channel
- axis_rdata (in, 32), axis_rresp (in, 2), axis_rdata_valid (in, 1), axis_rdata_ready (out, 1): read data channel

## Operation
- States:
  - IDLE: cmd_ready=1.
  - WR_REQ: waddr and wdata channels in flight.
  - WR_RESP: bresp_ready=1.
  - RD_REQ: raddr_valid=1.
  - RD_DATA: rdata_ready=1.
  - RESP: rsp_valid=1.
- IDLE: on cmd_valid&&cmd_ready, latch addr, wdata and write. Next state is WR_REQ if write, RD_REQ if read.
- WR_REQ:
  - axis_waddr_valid and axis_wdata_valid assert together.
  - Each channel has its own done flag. Each valid clears on the edge where valid&&ready is sampled.
  - Leave WR_REQ when both flags are set, including when both handshakes land in the same cycle.
- WR_RESP: on axis_bresp_valid, capture axis_bresp into rsp_resp, set rsp_rdata=0, go to RESP.
- RD_REQ: on axis_raddr_ready, drop axis_raddr_valid and go to RD_DATA.
- RD_DATA: on axis_rdata_valid, capture axis_rdata and axis_rresp, go to RESP.
- RESP: hold rsp_* stable until rsp_ready, then go to IDLE.
- Valid rules:
  - Once asserted, an AXI valid never drops before its handshake.
  - axis_bresp_ready and axis_rdata_ready assert only in WR_RESP and RD_DATA respectively.
  - Any ready that arrives before valid is ignored.
- No response codes are interpreted. SLVERR/DECERR pass through unchanged. There is no timeout.
- Reset, including mid-transaction: all state returns to IDLE asynchronously and the in-flight transaction is abandoned.
  - Reset values: cmd_ready=1; every other output 0; axis_waddr, axis_raddr and axis_wdata 0.

## Timing
- Command handshake at edge T: channel valids are high from T+1 (registered); cmd_ready is low from T+1.
- Write with zero-wait slave (ready already high, bresp_valid one cycle after the last W/AW handshake):
  - AW/W handshake at T+1, WR_RESP at T+2, B handshake at T+3.
  - rsp_valid high at T+4. Next cmd_ready at T+5 if rsp_ready is held high.
- Read with zero-wait slave: AR handshake at T+1, R handshake at T+2, rsp_valid at T+3.
- Minimum command-to-command period: 5 cycles for a write, 4 for a read.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package axi_lite_pkg holds:
  - Response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The DATA_WIDTH constant.
  - The initiator state encodings (3-bit).
- Single module with no sub-module. The AW/W done-flag pair is small enough to live inline.

## Test plan
- Write 0x0000_0004 ← 0xDEAD_BEEF, zero-wait slave -> one AW and one W beat with those values, rsp_valid at T+4, rsp_resp=00, rsp_write=1.
- Write with wdata_ready delayed 3 cycles after waddr_ready -> axis_waddr_valid drops after its beat, axis_wdata_valid holds until its beat, and bresp_ready does not rise before both beats.
- Read 0x0000_0008, slave returns 0x1234_5678 with RRESP=00 after 2 wait cycles -> rsp_rdata=0x1234_5678, rsp_resp=00, rsp_write=0.
- Read 0x0000_0013, slave returns RRESP=10 -> rsp_resp=10 passed through; the next command is accepted normally.
- rsp_ready held low for 6 cycles -> rsp_* stable throughout, cmd_ready=0, and a pending cmd_valid is not accepted.
- axis_rst_n asserted while in WR_REQ with valids high -> all valids 0 immediately and cmd_ready=1; after release, a read completes correctly.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, data width and the
// initiator state encoding used by axi_lite_initiator.
package axi_lite_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } init_state_t;

endpackage

// File: rtl/axi_lite_initiator_if.sv
// AXI-Lite five-channel bundle (AW, W, B, AR, R).
// master drives addresses, write data, valids and response readies.
interface axi_lite_initiator_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] axis_waddr;
    logic                  axis_waddr_valid;
    logic                  axis_waddr_ready;

    logic [DATA_WIDTH-1:0] axis_wdata;
    logic                  axis_wdata_valid;
    logic                  axis_wdata_ready;

    logic [1:0]            axis_bresp;
    logic                  axis_bresp_valid;
    logic                  axis_bresp_ready;

    logic [ADDR_WIDTH-1:0] axis_raddr;
    logic                  axis_raddr_valid;
    logic                  axis_raddr_ready;

    logic [DATA_WIDTH-1:0] axis_rdata;
    logic [1:0]            axis_rresp;
    logic                  axis_rdata_valid;
    logic                  axis_rdata_ready;

    modport master (
        output axis_waddr, axis_waddr_valid,
        input  axis_waddr_ready,
        output axis_wdata, axis_wdata_valid,
        input  axis_wdata_ready,
        input  axis_bresp, axis_bresp_valid,
        output axis_bresp_ready,
        output axis_raddr, axis_raddr_valid,
        input  axis_raddr_ready,
        input  axis_rdata, axis_rresp, axis_rdata_valid,
        output axis_rdata_ready
    );

    modport slave (
        input  axis_waddr, axis_waddr_valid,
        output axis_waddr_ready,
        input  axis_wdata, axis_wdata_valid,
        output axis_wdata_ready,
        output axis_bresp, axis_bresp_valid,
        input  axis_bresp_ready,
        input  axis_raddr, axis_raddr_valid,
        output axis_raddr_ready,
        output axis_rdata, axis_rresp, axis_rdata_valid,
        input  axis_rdata_ready
    );

endinterface

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI-Lite initiator: cmd_* in, rsp_* out, AXI on axis.
// Ports: axis_clk/axis_rst_n, cmd/rsp handshakes, busy, axis (master).
module axi_lite_initiator
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    axi_lite_initiator_if.master  axis
);

    init_state_t state_q;
    init_state_t state_d;

    logic aw_done;
    logic w_done;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic rsp_hs;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = axis.axis_waddr_valid && axis.axis_waddr_ready;
    assign w_hs   = axis.axis_wdata_valid && axis.axis_wdata_ready;
    assign b_hs   = axis.axis_bresp_valid && axis.axis_bresp_ready;
    assign ar_hs  = axis.axis_raddr_valid && axis.axis_raddr_ready;
    assign r_hs   = axis.axis_rdata_valid && axis.axis_rdata_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A done flag or a handshake this cycle both count as finished,
    // so AW and W landing together still leave in one step.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next state, so nothing
    // combinational reaches the ports.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            cmd_ready             <= 1'b1;
            busy                  <= 1'b0;
            rsp_valid             <= 1'b0;
            rsp_write             <= 1'b0;
            rsp_rdata             <= '0;
            rsp_resp              <= '0;
            aw_done               <= 1'b0;
            w_done                <= 1'b0;
            axis.axis_waddr       <= '0;
            axis.axis_waddr_valid <= 1'b0;
            axis.axis_wdata       <= '0;
            axis.axis_wdata_valid <= 1'b0;
            axis.axis_bresp_ready <= 1'b0;
            axis.axis_raddr       <= '0;
            axis.axis_raddr_valid <= 1'b0;
            axis.axis_rdata_ready <= 1'b0;
        end else begin
            cmd_ready             <= (state_d == ST_IDLE);
            busy                  <= (state_d != ST_IDLE);
            rsp_valid             <= (state_d == ST_RESP);
            axis.axis_bresp_ready <= (state_d == ST_WR_RESP);
            axis.axis_raddr_valid <= (state_d == ST_RD_REQ);
            axis.axis_rdata_ready <= (state_d == ST_RD_DATA);

            if (cmd_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (cmd_write) begin
                    axis.axis_waddr       <= cmd_addr;
                    axis.axis_wdata       <= cmd_wdata;
                    axis.axis_waddr_valid <= 1'b1;
                    axis.axis_wdata_valid <= 1'b1;
                end else begin
                    axis.axis_raddr <= cmd_addr;
                end
            end

            if (aw_hs) begin
                axis.axis_waddr_valid <= 1'b0;
                aw_done               <= 1'b1;
            end

            if (w_hs) begin
                axis.axis_wdata_valid <= 1'b0;
                w_done                <= 1'b1;
            end

            if (b_hs) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= axis.axis_bresp;
            end

            if (r_hs) begin
                rsp_write <= 1'b0;
                rsp_rdata <= axis.axis_rdata;
                rsp_resp  <= axis.axis_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: directed plan steps plus random traffic
// against a memory-backed slave and an address-map reference model.
module tb_axi_lite_initiator;
    import axi_lite_pkg::*;

    localparam int AW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    axi_lite_initiator_if #(.ADDR_WIDTH(AW)) ifc ();

    axi_lite_initiator #(.ADDR_WIDTH(AW)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .busy       (busy),
        .axis       (ifc)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave backing store: unwritten locations read as ~addr.
    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : ~a;
    endfunction

    // Reference: what the controller should read back at an address.
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : ~a;
    endfunction

    task automatic slave_idle();
        ifc.axis_waddr_ready = 1'b0;
        ifc.axis_wdata_ready = 1'b0;
        ifc.axis_bresp_valid = 1'b0;
        ifc.axis_bresp       = 2'b00;
        ifc.axis_raddr_ready = 1'b0;
        ifc.axis_rdata_valid = 1'b0;
        ifc.axis_rdata       = 32'h0;
        ifc.axis_rresp       = 2'b00;
    endtask

    task automatic finish_rsp(input bit w, input logic [31:0] rd,
                              input logic [1:0] rs, input int dly,
                              input bit pend);
        bit unstable;
        unstable = 1'b0;
        chk("rsp_fields",
            {rsp_valid, rsp_write, rs === rsp_resp, rsp_rdata, cmd_ready},
            {1'b1, w, 1'b1, rd, 1'b0});
        chk("rsp_code", rsp_resp, rs);
        if (pend) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h40;
            cmd_wdata = 32'h5555_AAAA;
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(posedge axis_clk); #1;
            if (rsp_valid !== 1'b1 || rsp_write !== w ||
                rsp_resp !== rs || rsp_rdata !== rd ||
                cmd_ready !== 1'b0 || busy !== 1'b1 ||
                ifc.axis_waddr_valid !== 1'b0 ||
                ifc.axis_raddr_valid !== 1'b0)
                unstable = 1'b1;
        end
        chk("rsp_stable", unstable, 1'b0);
        rsp_ready = 1'b1;
        @(posedge axis_clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_done",
            {rsp_valid, cmd_ready, busy,
             ifc.axis_waddr_valid, ifc.axis_wdata_valid,
             ifc.axis_raddr_valid},
            6'b010000);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] rs,
                            input int rsp_dly, input bit pend);
        int cyc;
        int both_at;
        int exp_lat;
        bit aw_done, w_done, b_done;
        bit aw_hs, w_hs, b_hs;
        bit hold_err, early_b;
        logic [31:0] got_a, got_d;
        cyc = 0; both_at = -1;
        aw_done = 0; w_done = 0; b_done = 0;
        hold_err = 0; early_b = 0;
        got_a = 'x; got_d = 'x;
        chk("wr_idle", {cmd_ready, busy}, 2'b10);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge axis_clk); #1;
        cmd_valid = 1'b0;
        chk("wr_start",
            {ifc.axis_waddr_valid, ifc.axis_wdata_valid, cmd_ready, busy},
            4'b1101);
        while (!b_done && cyc < 64) begin
            if (aw_done == ifc.axis_waddr_valid) hold_err = 1'b1;
            if (w_done == ifc.axis_wdata_valid) hold_err = 1'b1;
            if (ifc.axis_raddr_valid !== 1'b0) hold_err = 1'b1;
            if (!(aw_done && w_done) && ifc.axis_bresp_ready)
                early_b = 1'b1;
            ifc.axis_waddr_ready = !aw_done && (cyc >= aw_dly);
            ifc.axis_wdata_ready = !w_done && (cyc >= w_dly);
            ifc.axis_bresp_valid = aw_done && w_done &&
                                   (cyc >= both_at + b_dly);
            ifc.axis_bresp = rs;
            aw_hs = ifc.axis_waddr_valid && ifc.axis_waddr_ready;
            w_hs  = ifc.axis_wdata_valid && ifc.axis_wdata_ready;
            b_hs  = ifc.axis_bresp_valid && ifc.axis_bresp_ready;
            if (aw_hs) got_a = ifc.axis_waddr;
            if (w_hs)  got_d = ifc.axis_wdata;
            @(posedge axis_clk); #1;
            cyc++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            if (aw_done && w_done && both_at < 0) both_at = cyc;
            if (b_hs) b_done = 1'b1;
        end
        slave_idle();
        exp_lat = (aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 2;
        chk("wr_complete", b_done, 1'b1);
        chk("wr_valid_hold", hold_err, 1'b0);
        chk("wr_early_bready", early_b, 1'b0);
        chk("wr_aw_addr", got_a, a);
        chk("wr_w_data", got_d, d);
        chk("wr_latency", cyc, exp_lat);
        if (w_done) slave_mem[got_a] = got_d;
        model_mem[a] = d;
        finish_rsp(1'b1, 32'h0, rs, rsp_dly, pend);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input int ar_dly, input int r_dly,
                           input logic [1:0] rs, input int rsp_dly);
        int cyc;
        int ar_at;
        bit ar_done, r_done;
        bit ar_hs, r_hs;
        bit hold_err, early_r;
        logic [31:0] got_a;
        cyc = 0; ar_at = -1;
        ar_done = 0; r_done = 0;
        hold_err = 0; early_r = 0;
        got_a = 'x;
        chk("rd_idle", {cmd_ready, busy}, 2'b10);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_wdata = 32'hFFFF_FFFF;
        @(posedge axis_clk); #1;
        cmd_valid = 1'b0;
        chk("rd_start", {ifc.axis_raddr_valid, ifc.axis_waddr_valid,
                         cmd_ready, busy}, 4'b1001);
        while (!r_done && cyc < 64) begin
            if (ar_done == ifc.axis_raddr_valid) hold_err = 1'b1;
            if (ifc.axis_waddr_valid !== 1'b0 ||
                ifc.axis_wdata_valid !== 1'b0) hold_err = 1'b1;
            if (!ar_done && ifc.axis_rdata_ready) early_r = 1'b1;
            ifc.axis_raddr_ready = !ar_done && (cyc >= ar_dly);
            ifc.axis_rdata_valid = ar_done && (cyc >= ar_at + r_dly);
            ifc.axis_rdata = ar_done ? slave_rd(got_a) : 32'h0;
            ifc.axis_rresp = rs;
            ar_hs = ifc.axis_raddr_valid && ifc.axis_raddr_ready;
            r_hs  = ifc.axis_rdata_valid && ifc.axis_rdata_ready;
            if (ar_hs) got_a = ifc.axis_raddr;
            @(posedge axis_clk); #1;
            cyc++;
            if (ar_hs) begin
                ar_done = 1'b1;
                ar_at = cyc;
            end
            if (r_hs) r_done = 1'b1;
        end
        slave_idle();
        chk("rd_complete", r_done, 1'b1);
        chk("rd_valid_hold", hold_err, 1'b0);
        chk("rd_early_rready", early_r, 1'b0);
        chk("rd_ar_addr", got_a, a);
        chk("rd_latency", cyc, ar_dly + r_dly + 2);
        finish_rsp(1'b0, exp_d, rs, rsp_dly, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rd;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        slave_idle();
        slave_mem[32'h8] = 32'h1234_5678;
        model_mem[32'h8] = 32'h1234_5678;

        #1 axis_rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {cmd_ready, busy, rsp_valid, rsp_write,
                           rsp_resp, rsp_rdata}, {4'b1000, 2'b00, 32'h0});
        chk("reset_axi", {ifc.axis_waddr_valid, ifc.axis_wdata_valid,
                          ifc.axis_bresp_ready, ifc.axis_raddr_valid,
                          ifc.axis_rdata_ready}, 5'b00000);
        chk("reset_bus", {ifc.axis_waddr, ifc.axis_wdata, ifc.axis_raddr},
            96'h0);
        @(posedge axis_clk); #1;
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;

        do_write(32'h0000_0004, 32'hDEAD_BEEF, 0, 0, 1, RESP_OKAY, 0, 0);
        do_write(32'h0000_0010, 32'h0BAD_F00D, 0, 3, 1, RESP_OKAY, 0, 0);
        do_read(32'h0000_0008, 32'h1234_5678, 0, 2, RESP_OKAY, 0);
        do_read(32'h0000_0013, model_rd(32'h13), 0, 0, RESP_SLVERR, 0);
        do_read(32'h0000_0004, model_rd(32'h4), 1, 0, RESP_OKAY, 0);
        do_write(32'h0000_0020, 32'hA5A5_5A5A, 2, 0, 0, RESP_DECERR, 6, 1);

        // abandon a write mid-flight with both valids up
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0100;
        cmd_wdata = 32'hCAFE_CAFE;
        @(posedge axis_clk); #1;
        cmd_valid = 1'b0;
        @(posedge axis_clk); #1;
        chk("rst_pre", {ifc.axis_waddr_valid, ifc.axis_wdata_valid, busy},
            3'b111);
        #2 axis_rst_n = 1'b0;
        #1;
        chk("rst_async", {ifc.axis_waddr_valid, ifc.axis_wdata_valid,
                          ifc.axis_bresp_ready, ifc.axis_raddr_valid,
                          ifc.axis_rdata_valid === 1'b0,
                          rsp_valid, cmd_ready, busy},
            8'b00001010);
        chk("rst_async_bus", {ifc.axis_waddr, ifc.axis_wdata,
                              ifc.axis_raddr}, 96'h0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        do_read(32'h0000_0004, 32'hDEAD_BEEF, 0, 0, RESP_OKAY, 0);
        do_read(32'h0000_0100, model_rd(32'h100), 0, 1, RESP_OKAY, 0);

        for (int n = 0; n < 24; n++) begin
            ra = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            rd = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(ra, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                         $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else
                do_read(ra, model_rd(ra), $urandom_range(0, 3),
                        $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                        $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
